// File: rtl/alu_issue_stage.sv
// Operand-issue / result-capture stage around the external ripple-carry adder.
// Holds adder operands for a settle window, then registers sum and flags.
module alu_issue_stage #(
   parameter int unsigned WIDTH         = 64,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_add_a;
   logic [WIDTH-1:0] r_add_b;
   logic             r_add_cin;
   logic [WIDTH-1:0] r_out_sum;
   logic             r_out_ovf;
   logic             r_out_zero;
   logic             r_out_neg;

   logic             w_accept;
   logic             w_capture;
   logic [WIDTH-1:0] w_b_cond;
   logic             w_cin_cond;

   assign w_accept  = in_valid && (r_state == S_IDLE);
   assign w_capture = (r_state == S_SETTLE) && (r_cnt == '0);

   always_comb begin
      w_b_cond   = '0;
      w_cin_cond = 1'b0;
      unique case (in_op)
         OP_ADD:  begin w_b_cond = in_b;  w_cin_cond = 1'b0; end
         OP_SUB:  begin w_b_cond = ~in_b; w_cin_cond = 1'b1; end
         OP_INC:  begin w_b_cond = '0;    w_cin_cond = 1'b1; end
         OP_PASS: begin w_b_cond = '0;    w_cin_cond = 1'b0; end
         default: begin w_b_cond = '0;    w_cin_cond = 1'b0; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (in_valid)  w_next = S_SETTLE;
         S_SETTLE: if (w_capture) w_next = S_DONE;
         S_DONE:   if (out_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_add_a    <= '0;
         r_add_b    <= '0;
         r_add_cin  <= 1'b0;
         r_out_sum  <= '0;
         r_out_ovf  <= 1'b0;
         r_out_zero <= 1'b0;
         r_out_neg  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_add_a   <= in_a;
            r_add_b   <= w_b_cond;
            r_add_cin <= w_cin_cond;
            r_cnt     <= CNT_LOAD;
         end else if (r_state == S_SETTLE && !w_capture) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // Sample the adder only once the ripple chain has had its settle window.
         if (w_capture) begin
            r_out_sum  <= add_sum;
            r_out_ovf  <= add_ovf;
            r_out_zero <= (add_sum == '0);
            r_out_neg  <= add_sum[WIDTH-1];
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign add_cin   = r_add_cin;
   assign out_sum   = r_out_sum;
   assign out_ovf   = r_out_ovf;
   assign out_zero  = r_out_zero;
   assign out_neg   = r_out_neg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 64-bit adder attached
// to the add_* port; expected results are hand-computed constants.
module tb_alu_issue_stage;

   localparam int unsigned W = 64;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic         add_cin;
   logic [W-1:0] add_sum;
   logic         add_ovf;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_ovf;
   logic         out_zero;
   logic         out_neg;

   int errors = 0;
   int checks = 0;

   alu_issue_stage #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_ovf(add_ovf),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
   );

   // Behavioural stand-in for the ripple-carry adder.
   always_comb begin
      add_sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};
      add_ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation and hold it through exactly one accept edge.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_a = '1; in_b = '1; in_op = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
      #12;
      checks++;
      if ({add_a, add_b, add_cin, out_sum, out_ovf, out_zero, out_neg, out_valid} !== '0) begin
         errors++; $display("FAIL reset_zero got a=%h b=%h cin=%b sum=%h flags=%b%b%b v=%b exp all 0",
                            add_a, add_b, add_cin, out_sum, out_ovf, out_zero, out_neg, out_valid);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_add();
      issue(2'b00, 64'd5, 64'd7);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL add_busy got rdy=%b v=%b exp 0 0", in_ready, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got=%b exp=0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 64'd12 || {out_ovf, out_zero, out_neg} !== 3'b000) begin
         errors++; $display("FAIL add_result got v=%b sum=%h flags=%b%b%b exp v=1 sum=c flags=000",
                            out_valid, out_sum, out_ovf, out_zero, out_neg);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL add_return got rdy=%b v=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_sub();
      issue(2'b01, 64'd3, 64'd5);
      checks++;
      if (add_a !== 64'd3 || add_b !== 64'hFFFF_FFFF_FFFF_FFFA || add_cin !== 1'b1) begin
         errors++; $display("FAIL sub_operands got a=%h b=%h cin=%b exp a=3 b=fffffffffffffffa cin=1",
                            add_a, add_b, add_cin);
      end
      tick(); tick();
      checks++;
      if (out_sum !== 64'hFFFF_FFFF_FFFF_FFFE || out_neg !== 1'b1 || out_ovf !== 1'b0 || out_zero !== 1'b0) begin
         errors++; $display("FAIL sub_neg got sum=%h ovf=%b zero=%b neg=%b exp sum=fffffffffffffffe 0 0 1",
                            out_sum, out_ovf, out_zero, out_neg);
      end
      tick();
      issue(2'b01, 64'h1234, 64'h1234);
      tick(); tick();
      checks++;
      if (out_sum !== 64'd0 || out_zero !== 1'b1 || out_neg !== 1'b0 || out_ovf !== 1'b0) begin
         errors++; $display("FAIL sub_zero got sum=%h ovf=%b zero=%b neg=%b exp sum=0 0 1 0",
                            out_sum, out_ovf, out_zero, out_neg);
      end
      tick();
   endtask

   task automatic test_overflow();
      issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      tick(); tick();
      checks++;
      if (out_sum !== 64'h8000_0000_0000_0000 || out_ovf !== 1'b1 || out_neg !== 1'b1) begin
         errors++; $display("FAIL ovf_add got sum=%h ovf=%b neg=%b exp sum=8000000000000000 1 1",
                            out_sum, out_ovf, out_neg);
      end
      tick();
      issue(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1234_5678);
      checks++;
      if (add_b !== 64'd0 || add_cin !== 1'b1) begin
         errors++; $display("FAIL inc_operands got b=%h cin=%b exp b=0 cin=1", add_b, add_cin);
      end
      tick(); tick();
      checks++;
      if (out_sum !== 64'h8000_0000_0000_0000 || out_ovf !== 1'b1 || out_neg !== 1'b1) begin
         errors++; $display("FAIL ovf_inc got sum=%h ovf=%b neg=%b exp sum=8000000000000000 1 1",
                            out_sum, out_ovf, out_neg);
      end
      tick();
      issue(2'b01, 64'd0, 64'h8000_0000_0000_0000);
      tick(); tick();
      checks++;
      if (out_sum !== 64'h8000_0000_0000_0000 || out_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_sub_minneg got sum=%h ovf=%b exp sum=8000000000000000 ovf=1",
                            out_sum, out_ovf);
      end
      tick();
   endtask

   task automatic test_pass();
      issue(2'b11, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
      checks++;
      if (add_b !== 64'd0 || add_cin !== 1'b0) begin
         errors++; $display("FAIL pass_operands got b=%h cin=%b exp b=0 cin=0", add_b, add_cin);
      end
      tick(); tick();
      checks++;
      if (out_sum !== 64'hDEAD_BEEF || out_ovf !== 1'b0 || out_zero !== 1'b0 || out_neg !== 1'b0) begin
         errors++; $display("FAIL pass_result got sum=%h ovf=%b zero=%b neg=%b exp sum=deadbeef 0 0 0",
                            out_sum, out_ovf, out_zero, out_neg);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      issue(2'b00, 64'd10, 64'd20);
      // Queue the next op immediately and keep it asserted through the stall.
      in_op = 2'b00; in_a = 64'd100; in_b = 64'd1; in_valid = 1'b1;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 64'd30 || in_ready !== 1'b0 ||
             add_a !== 64'd10 || add_b !== 64'd20 || add_cin !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d] got v=%b sum=%h rdy=%b a=%h b=%h cin=%b exp 1 1e 0 a 14 0",
                               i, out_valid, out_sum, in_ready, add_a, add_b, add_cin);
         end
         in_a = 64'd100 + 64'(i); in_b = 64'd1;
         tick();
      end
      in_a = 64'd100;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL stall_release got v=%b rdy=%b exp 0 1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || add_a !== 64'd100 || add_b !== 64'd1) begin
         errors++; $display("FAIL queued_accept got rdy=%b a=%h b=%h exp 0 64 1", in_ready, add_a, add_b);
      end
      tick(); tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 64'd101) begin
         errors++; $display("FAIL queued_result got v=%b sum=%h exp v=1 sum=65", out_valid, out_sum);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(2'b00, 64'd9, 64'd9);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({add_a, add_b, add_cin, out_sum, out_ovf, out_zero, out_neg, out_valid} !== '0) begin
         errors++; $display("FAIL midreset_clear got a=%h b=%h sum=%h v=%b exp all 0",
                            add_a, add_b, out_sum, out_valid);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_novalid[%0d] got v=%b rdy=%b exp 0 1", i, out_valid, in_ready);
         end
      end
      issue(2'b00, 64'd1, 64'd1);
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_early got v=%b exp 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 64'd2) begin
         errors++; $display("FAIL post_reset_add got v=%b sum=%h exp v=1 sum=2", out_valid, out_sum);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_pass();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and result-capture stage wrapped around the 64-bit ripple-carry adder in the ALU. It accepts one ALU operation per valid/ready handshake and derives the adder operands and carry-in from a 2-bit opcode. It then holds those operands stable for a programmable settle window while the ripple chain resolves. Finally it registers the sum, the adder's overflow, and derived zero/negative flags into an output register with its own valid/ready handshake.

## Interface
- WIDTH, 64, datapath width; must match the adder width.
- SETTLE_CYCLES, 2, number of clock edges after issue before the adder result is sampled; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  stage can accept an operation; high only in IDLE.
- in_op  input  2  opcode: 00 ADD, 01 SUB, 10 INC, 11 PASS.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B; ignored for INC and PASS.
- add_a  output  WIDTH  registered operand A to adder.
- add_b  output  WIDTH  registered, opcode-conditioned operand B to adder.
- add_cin  output  1  registered carry-in to adder.
- add_sum  input  WIDTH  adder sum.
- add_ovf  input  1  adder signed-overflow flag.
- out_valid  output  1  result registers valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  captured sum.
- out_ovf  output  1  captured signed overflow.
- out_zero  output  1  captured sum equals 0.
- out_neg  output  1  captured sum MSB.

## Operation
- States: IDLE, SETTLE, DONE. Encoding is free.
- **IDLE**
  - in_ready=1.
  - On in_valid && in_ready:
    - load add_a=in_a;
    - load add_b/add_cin per opcode:
      - ADD: b, 0
      - SUB: ~b, 1
      - INC: 0, 1
      - PASS: 0, 0
    - set the counter to SETTLE_CYCLES-1;
    - go to SETTLE.
- **SETTLE**
  - add_* hold.
  - If counter==0:
    - capture out_sum=add_sum, out_ovf=add_ovf, out_zero=(add_sum==0), out_neg=add_sum[WIDTH-1];
    - go to DONE.
  - Otherwise decrement the counter.
- **DONE**
  - out_valid=1; all out_* and add_* hold.
  - On out_ready go to IDLE.
  - No same-cycle re-accept: in_ready=0 in DONE.
- Overflow comes solely from the adder, with sign rules applied to add_a/add_b as issued. SUB overflow is therefore correct via the ~b+1 form, including B = most-negative value. PASS always yields out_ovf=0.
- No carry-out is exported or stored.
- in_op, in_a and in_b are sampled only on the accept edge. Changes at other times have no effect.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, counter=0;
  - add_a=0, add_b=0, add_cin=0;
  - out_sum=0, out_ovf=0, out_zero=0, out_neg=0, out_valid=0;
  - in_ready=1 once rst_n deasserts.
- Reset asserted mid-SETTLE or mid-DONE aborts the operation immediately. The pending result is lost and no out_valid pulse occurs.
- Latency: for an accept at edge N, results are captured and out_valid rises at edge N+SETTLE_CYCLES. With the default, that is edge N+2.
- Handshake completion at edge M (out_valid && out_ready) lowers out_valid at M. in_ready is high during cycle M→M+1, so the next accept is possible at edge M+1.
- Peak throughput: one operation per SETTLE_CYCLES+2 cycles.
- out_ready held low keeps DONE indefinitely, with outputs stable.
- out_ready high before DONE has no effect.
- in_valid may be held high across busy cycles. Only one accept occurs per IDLE visit.

## Test plan
- ADD 5 + 7, out_ready=1 → out_valid 2 cycles after accept; out_sum=12, out_ovf=0, out_zero=0, out_neg=0; in_ready back high the cycle after.
- SUB 3 − 5 → add_b=~5, add_cin=1; out_sum=0xFFFF_FFFF_FFFF_FFFE, out_neg=1, out_ovf=0. Then SUB 0x1234 − 0x1234 → out_sum=0, out_zero=1.
- Overflow cases:
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → out_sum=0x8000_0000_0000_0000, out_ovf=1, out_neg=1.
  - INC of the same A → identical result.
  - SUB 0 − 0x8000_0000_0000_0000 → out_ovf=1.
- PASS A=0xDEAD_BEEF, B=0xFFFF… → out_sum=0xDEAD_BEEF, out_ovf=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_valid, out_* and add_* stable and in_ready=0 throughout. Raise out_ready → one transfer, then the next queued in_valid is accepted one cycle later.
- Pulse rst_n low one cycle after an accept (in SETTLE) → all outputs 0 immediately, no out_valid. After release, ADD 1 + 1 → out_sum=2 with normal latency.
